// File: rtl/mult_div.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit, 32 iterations.
// Results land in hi/lo with a single done pulse; a zero divisor completes at once with div_zero.
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state;
  logic [32:0] acc_hi;   // mult: P_hi with a guard bit; div: partial remainder in [31:0]
  logic [31:0] acc_lo;   // mult: P_lo; div: dividend shifting out / quotient shifting in
  logic        acc_q;    // Booth q-1 bit
  logic [31:0] opnd;     // multiplicand, or divisor magnitude
  logic        neg_q;
  logic        neg_r;
  logic [5:0]  cnt;

  logic [31:0] abs_a, abs_b;
  logic [32:0] m_ext, booth_sum, trial;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    abs_a = a[31] ? (32'd0 - a) : a;
    abs_b = b[31] ? (32'd0 - b) : b;
    // guard bit keeps the -(-2^31) Booth subtract from overflowing
    m_ext = {opnd[31], opnd};
    booth_sum = acc_hi;
    case ({acc_lo[0], acc_q})
      2'b01:   booth_sum = acc_hi + m_ext;
      2'b10:   booth_sum = acc_hi - m_ext;
      default: booth_sum = acc_hi;
    endcase
    trial = {acc_hi[31:0], acc_lo[31]};
    ge    = (trial >= {1'b0, opnd});
    diff  = trial[31:0] - opnd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc_hi   <= '0;
      acc_lo   <= '0;
      acc_q    <= 1'b0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_q  <= 1'b0;
            if (op && (b == 32'd0)) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else if (op) begin
              state  <= DIV;
              busy   <= 1'b1;
              opnd   <= abs_b;
              acc_lo <= abs_a;
              neg_q  <= a[31] ^ b[31];
              neg_r  <= a[31];
            end else begin
              state  <= MULT;
              busy   <= 1'b1;
              opnd   <= a;
              acc_lo <= b;
            end
          end else begin
            state <= IDLE;
          end
        end
        MULT: begin
          if (cnt == 6'd32) begin
            hi    <= acc_hi[31:0];
            lo    <= acc_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc_hi <= {booth_sum[32], booth_sum[32:1]};
            acc_lo <= {booth_sum[0], acc_lo[31:1]};
            acc_q  <= acc_lo[0];
            cnt    <= cnt + 6'd1;
          end
        end
        DIV: begin
          if (cnt == 6'd32) begin
            hi    <= neg_r ? (32'd0 - acc_hi[31:0]) : acc_hi[31:0];
            lo    <= neg_q ? (32'd0 - acc_lo) : acc_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc_hi <= {1'b0, (ge ? diff : trial[31:0])};
            acc_lo <= {acc_lo[30:0], ge};
            cnt    <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: vector table of mult/div results plus
// hand sequences for divide-by-zero, ignored start, back-to-back and mid-op reset.
module tb_mult_div;

  logic        clock, reset, start, op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // waits up to 40 edges for done; returns the edge count (-1 on timeout)
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (n == 32) chk("busy_at_e32", {31'd0, busy}, 32'd1);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D;
    chk("busy_at_e0", {31'd0, busy}, 32'd1);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3]  = '{1'b0, 32'h7FFFFFFF,  32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[4]  = '{1'b0, 32'h80000000,  32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
    vecs[5]  = '{1'b0, 32'h12345678,  32'd0,        32'h00000000, 32'h00000000};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[9]  = '{1'b1, 32'd100,       32'd7,        32'h00000002, 32'h0000000E};
    vecs[10] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
    vecs[11] = '{1'b1, 32'd3,         32'd5,        32'h00000003, 32'h00000000};
    vecs[12] = '{1'b1, 32'h80000000,  32'h80000000, 32'h00000000, 32'h00000001};
    vecs[13] = '{1'b1, 32'h00000451,  32'h00000020, 32'h00000011, 32'h00000022};

    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clock); reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 33);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_flags", i), {30'd0, busy, div_zero}, 32'd0);
      @(posedge clock); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // divide by zero right after hi=0x11 / lo=0x22 from the last vector
    @(negedge clock);
    start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
    @(posedge clock); #1;
    start = 1'b0;
    chk("dz_done", {31'd0, done}, 32'd1);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    chk("dz_hi_kept", hi, 32'h11);
    chk("dz_lo_kept", lo, 32'h22);
    @(posedge clock); #1;
    chk("dz_pulse_end", {30'd0, done, div_zero}, 32'd0);

    // start while busy is ignored, operand changes have no effect
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clock); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 11) begin
        start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd0;
      end else begin
        start = 1'b0; a = 32'd1000 + n; b = 32'd77;
      end
      @(posedge clock); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk("busy_ign_latency", lat, 33);
    chk("busy_ign_lo", lo, 32'd12);
    chk("busy_ign_hi", hi, 32'd0);
    chk("busy_ign_dz", {31'd0, div_zero}, 32'd0);

    // back-to-back: start during the DONE cycle
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done(lat);
    chk("b2b_latency", lat, 33);
    chk("b2b_lo", lo, 32'd30);
    chk("b2b_hi", hi, 32'd0);

    // reset mid-operation
    @(negedge clock);
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (done || busy) lat++;
    end
    chk("rst_no_done", lat, 0);
    run_op(1'b1, 32'd1000, 32'd3, lat);
    chk("post_rst_latency", lat, 33);
    chk("post_rst_lo", lo, 32'd333);
    chk("post_rst_hi", hi, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Sequential signed multiply/divide unit for the multicycle CPU datapath. It sits directly downstream of the MDSrcA/MDSrcB operand multiplexers and upstream of the HI and LO registers. It executes MIPS `mult` and `div` in 32 iterations and hands results, a completion pulse and a divide-by-zero indication to the control unit. The control unit uses the divide-by-zero indication to redirect to the Div0 exception vector.

## Interface
- Parameters: none (datapath fixed at 32 bits)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only when not busy
- op  in  1  0 = signed multiply, 1 = signed divide
- a  in  32  operand A (MDSrcA_out): multiplicand / dividend
- b  in  32  operand B (MDSrcB_out): multiplier / divisor
- hi  out  32  multiply: upper product word; divide: remainder
- lo  out  32  multiply: lower product word; divide: quotient
- busy  out  1  high while iterating
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse, coincident with done, when dividing by 0

## Operation
- **States:** IDLE, MULT, DIV, DONE.
- **Accepting a start:**
  - In IDLE or DONE, `start` = 1 at a rising edge latches a, b and op into internal registers.
  - The state then goes to MULT (op = 0) or DIV (op = 1). Iteration counter is loaded to 0.
  - Operand port changes after this edge have no effect.
  - `start` while busy is ignored.
- **MULT:**
  - Radix-2 Booth on a 65-bit accumulator {P_hi, P_lo, q-1}, one step per cycle, 32 steps.
  - Each step: add/subtract the multiplicand in two's complement on P_hi per the Booth pair, then an arithmetic right shift of the full accumulator.
  - Product is the exact signed 64-bit result.
- **DIV:**
  - Restoring division on magnitudes |a| and |b|, one quotient bit per cycle, 32 steps.
  - Sign fix applied when writing results:
    - quotient is negated if sign(a) ≠ sign(b) (truncation toward zero);
    - remainder takes the sign of a.
  - Magnitudes and negation use 32-bit wraparound, so 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0.
- **Divide by zero:**
  - Applies when op = 1 and b = 0 at the start edge.
  - Goes directly to DONE; no iteration.
  - div_zero = 1 and done = 1 in that DONE cycle; hi/lo keep their previous values.
- **Leaving MULT/DIV:** after the 32nd step → DONE.
  - hi/lo are written on that same edge.
  - div_zero stays 0 on all non-zero-divisor completions.
- **DONE:** lasts one cycle, then IDLE, unless start is accepted (back-to-back operation).
- **Output holding:** hi/lo hold their values until the next completion or reset. They never show partial results, because the accumulators are internal.
- **Reset (asynchronous, active-low):**
  - Effect: state = IDLE; hi = lo = 0; busy = done = div_zero = 0; internal accumulators and counter are cleared.
  - An operation in flight is abandoned with no done pulse.

## Timing
- Start accepted at edge E0; busy = 1 from E0 through the edge E32.
- Edge E33: state enters DONE; hi/lo updated; done = 1 for exactly one cycle (E33 → E34); busy = 0.
- Latency: 33 edges from accept to done, for both mult and div.
- Divide by zero: done = div_zero = 1 in the cycle after E0 (latency 1); busy never rises.
- Back-to-back: start high during the DONE cycle is accepted at E34. The next done arrives at E67.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Multiply, negative result:** mult a = 7, b = 0xFFFFFFFD (−3) → after 33 edges done = 1 with hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, div_zero = 0; busy high for exactly 32 cycles.
- **Multiply, extreme operands:** mult 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000. Also mult 0xFFFFFFFF × 0xFFFFFFFF → hi = 0, lo = 1.
- **Divide, signed:**
  - −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - 7 / −2 → lo = 0xFFFFFFFD, hi = 1.
  - 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero:** prior result hi = 0x11, lo = 0x22; div 5 / 0 → one edge later done = div_zero = 1 for one cycle; hi = 0x11, lo = 0x22 unchanged; busy stays 0.
- **Start while busy and operand changes:** start mult 3 × 4; pulse start with op = 1 and change a/b at iteration 10 → ignored; done at E33 with lo = 12, hi = 0. Then start again in the DONE cycle → accepted; second done 33 edges later.
- **Reset mid-operation:** assert reset (low) during iteration 15 → immediately hi = lo = 0, busy = done = div_zero = 0; after release, no done pulse appears and the next start runs normally.
